alu_operand_stage: RTL and testbench

//  Stage directly downstream of the ALU instruction decoder. Accepts one decoded ALU instruction per handshake.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_register_bank.sv | 39 +++
 rtl/alu_operand_stage.sv | 146 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand stage.
// Imported by the register bank and the stage top.
package alu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_REGS   = 16;
   localparam int SEL_WIDTH  = 4;

   localparam logic [2:0] ALU_OP_ADD  = 3'b000;
   localparam logic [2:0] ALU_OP_SUB  = 3'b100;
   localparam logic [2:0] ALU_OP_COPY = 3'b010;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [SEL_WIDTH-1:0]  sel_t;

endpackage

// File: rtl/alu_register_bank.sv
// 16x32 register bank: 4 read ports with write-first bypass,
// 2 write ports with Y2 priority, register 0 hardwired to zero.
module alu_register_bank
   import alu_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  sel_t  rd_sel  [4],
   output data_t rd_data [4],
   input  logic  y1_en,
   input  sel_t  y1_sel,
   input  data_t y1_data,
   input  logic  y2_en,
   input  sel_t  y2_sel,
   input  data_t y2_data
);

   data_t regs [NUM_REGS];

   // Y2 is written last so it wins a same-register collision.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         regs <= '{default: '0};
      end else begin
         if (y1_en && y1_sel != '0) regs[y1_sel] <= y1_data;
         if (y2_en && y2_sel != '0) regs[y2_sel] <= y2_data;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rd_data[i] = regs[rd_sel[i]];
         if (y1_en && y1_sel == rd_sel[i]) rd_data[i] = y1_data;
         if (y2_en && y2_sel == rd_sel[i]) rd_data[i] = y2_data;
         if (rd_sel[i] == '0) rd_data[i] = '0;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: register reads, RAW scoreboard,
// registered operand bundle towards the ALU.
module alu_operand_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_invalid,
   input  logic [2:0]  in_alu_op,
   input  logic        in_alu_form,
   input  logic [1:0]  in_vec_perci,
   input  logic [3:0]  in_alu_config,
   input  logic [3:0]  in_logic_select,
   input  logic        in_const_c,
   input  logic [31:0] in_constant,
   input  logic [3:0]  in_a_sel,
   input  logic [3:0]  in_b_sel,
   input  logic [3:0]  in_c_sel,
   input  logic [3:0]  in_d_sel,
   input  logic [3:0]  in_y1_sel,
   input  logic [3:0]  in_y2_sel,
   input  logic [1:0]  in_write,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [31:0] op_c,
   output logic [31:0] op_d,
   output logic [2:0]  out_alu_op,
   output logic        out_alu_form,
   output logic [1:0]  out_vec_perci,
   output logic [3:0]  out_alu_config,
   output logic [3:0]  out_logic_select,
   output logic [3:0]  out_y1_sel,
   output logic [3:0]  out_y2_sel,
   output logic [1:0]  out_write,
   input  logic        wb_y1_en,
   input  logic [3:0]  wb_y1_sel,
   input  logic [31:0] wb_y1_data,
   input  logic        wb_y2_en,
   input  logic [3:0]  wb_y2_sel,
   input  logic [31:0] wb_y2_data,
   output logic        illegal_instr
);

   sel_t  rd_sel  [4];
   data_t rd_data [4];

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_set;
   logic [NUM_REGS-1:0] busy_clr;
   logic [NUM_REGS-1:0] pending;
   logic                hazard;
   logic                capture;
   logic                take;

   assign rd_sel[0] = in_a_sel;
   assign rd_sel[1] = in_b_sel;
   assign rd_sel[2] = in_c_sel;
   assign rd_sel[3] = in_d_sel;

   alu_register_bank u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_sel  (rd_sel),
      .rd_data (rd_data),
      .y1_en   (wb_y1_en),
      .y1_sel  (wb_y1_sel),
      .y1_data (wb_y1_data),
      .y2_en   (wb_y2_en),
      .y2_sel  (wb_y2_sel),
      .y2_data (wb_y2_data)
   );

   always_comb begin
      busy_clr = '0;
      if (wb_y1_en) busy_clr[wb_y1_sel] = 1'b1;
      if (wb_y2_en) busy_clr[wb_y2_sel] = 1'b1;
   end

   // A writeback landing this cycle bypasses its busy bit.
   assign pending = busy & ~busy_clr;
   assign hazard  = pending[in_a_sel] | pending[in_b_sel]
                  | pending[in_d_sel]
                  | (!in_const_c & pending[in_c_sel]);

   assign in_ready = (!out_valid | out_ready) & !(in_valid & hazard);
   assign capture  = in_valid & in_ready;
   assign take     = capture & !in_invalid;

   always_comb begin
      busy_set = '0;
      if (take && in_write[0]) busy_set[in_y1_sel] = 1'b1;
      if (take && in_write[1]) busy_set[in_y2_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy <= '0;
      end else begin
         busy <= ((busy & ~busy_clr) | busy_set)
               & {{(NUM_REGS-1){1'b1}}, 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid        <= 1'b0;
         illegal_instr    <= 1'b0;
         op_a             <= '0;
         op_b             <= '0;
         op_c             <= '0;
         op_d             <= '0;
         out_alu_op       <= '0;
         out_alu_form     <= 1'b0;
         out_vec_perci    <= '0;
         out_alu_config   <= '0;
         out_logic_select <= '0;
         out_y1_sel       <= '0;
         out_y2_sel       <= '0;
         out_write        <= '0;
      end else begin
         illegal_instr <= capture & in_invalid;
         if (take) begin
            out_valid        <= 1'b1;
            op_a             <= rd_data[0];
            op_b             <= rd_data[1];
            op_c             <= in_const_c ? in_constant : rd_data[2];
            op_d             <= rd_data[3];
            out_alu_op       <= in_alu_op;
            out_alu_form     <= in_alu_form;
            out_vec_perci    <= in_vec_perci;
            out_alu_config   <= in_alu_config;
            out_logic_select <= in_logic_select;
            out_y1_sel       <= in_y1_sel;
            out_y2_sel       <= in_y2_sel;
            out_write        <= in_write;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table,
// scoreboard queue, and hand sequences for stalls and reset.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, in_invalid;
   logic [2:0]  in_alu_op;
   logic        in_alu_form;
   logic [1:0]  in_vec_perci;
   logic [3:0]  in_alu_config, in_logic_select;
   logic        in_const_c;
   logic [31:0] in_constant;
   logic [3:0]  in_a_sel, in_b_sel, in_c_sel, in_d_sel;
   logic [3:0]  in_y1_sel, in_y2_sel;
   logic [1:0]  in_write;
   logic        out_valid, out_ready;
   logic [31:0] op_a, op_b, op_c, op_d;
   logic [2:0]  out_alu_op;
   logic        out_alu_form;
   logic [1:0]  out_vec_perci;
   logic [3:0]  out_alu_config, out_logic_select;
   logic [3:0]  out_y1_sel, out_y2_sel;
   logic [1:0]  out_write;
   logic        wb_y1_en, wb_y2_en;
   logic [3:0]  wb_y1_sel, wb_y2_sel;
   logic [31:0] wb_y1_data, wb_y2_data;
   logic        illegal_instr;

   alu_operand_stage dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_invalid(in_invalid), .in_alu_op(in_alu_op),
      .in_alu_form(in_alu_form), .in_vec_perci(in_vec_perci),
      .in_alu_config(in_alu_config),
      .in_logic_select(in_logic_select),
      .in_const_c(in_const_c), .in_constant(in_constant),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
      .in_c_sel(in_c_sel), .in_d_sel(in_d_sel),
      .in_y1_sel(in_y1_sel), .in_y2_sel(in_y2_sel),
      .in_write(in_write),
      .out_valid(out_valid), .out_ready(out_ready),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .out_alu_op(out_alu_op), .out_alu_form(out_alu_form),
      .out_vec_perci(out_vec_perci),
      .out_alu_config(out_alu_config),
      .out_logic_select(out_logic_select),
      .out_y1_sel(out_y1_sel), .out_y2_sel(out_y2_sel),
      .out_write(out_write),
      .wb_y1_en(wb_y1_en), .wb_y1_sel(wb_y1_sel),
      .wb_y1_data(wb_y1_data),
      .wb_y2_en(wb_y2_en), .wb_y2_sel(wb_y2_sel),
      .wb_y2_data(wb_y2_data),
      .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a, b, c, d;
      logic [2:0]  op;
      logic        form;
      logic [1:0]  perci;
      logic [3:0]  cfg, ls, y1, y2;
      logic [1:0]  wr;
   } exp_t;

   typedef struct {
      logic [3:0]  a, b, c, d;
      logic        cc;
      logic [31:0] k;
      logic [2:0]  op;
      logic [31:0] ea, eb, ec, ed;
   } vec_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard: compare each bundle as the ALU takes it.
   always @(negedge clk) begin
      exp_t got, e;
      if (reset_n && out_valid && out_ready) begin
         got = '{op_a, op_b, op_c, op_d, out_alu_op,
                 out_alu_form, out_vec_perci, out_alu_config,
                 out_logic_select, out_y1_sel, out_y2_sel,
                 out_write};
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL bundle unexpected got %h", got);
         end else begin
            e = q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL bundle got %h want %h", got, e);
            end
         end
      end
   end

   task automatic drive(input logic [3:0] a, b, c, d,
                        input logic cc,
                        input logic [31:0] k,
                        input logic [2:0] op,
                        input logic [3:0] y1, y2,
                        input logic [1:0] wr);
      in_a_sel        = a;
      in_b_sel        = b;
      in_c_sel        = c;
      in_d_sel        = d;
      in_const_c      = cc;
      in_constant     = k;
      in_alu_op       = op;
      in_y1_sel       = y1;
      in_y2_sel       = y2;
      in_write        = wr;
      in_alu_form     = a[0];
      in_vec_perci    = b[1:0];
      in_alu_config   = c ^ d;
      in_logic_select = ~a;
   endtask

   task automatic push(input logic [31:0] ea, eb, ec, ed);
      q.push_back('{ea, eb, ec, ed, in_alu_op, in_alu_form,
                    in_vec_perci, in_alu_config,
                    in_logic_select, in_y1_sel, in_y2_sel,
                    in_write});
   endtask

   task automatic issue(input logic [3:0] a, b, c, d,
                        input logic cc,
                        input logic [31:0] k,
                        input logic [2:0] op,
                        input logic [3:0] y1, y2,
                        input logic [1:0] wr,
                        input logic [31:0] ea, eb, ec, ed);
      bit done = 0;
      drive(a, b, c, d, cc, k, op, y1, y2, wr);
      in_valid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            push(ea, eb, ec, ed);
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue timeout a_sel %0d", a);
      end
   endtask

   task automatic do_wb(input logic e1, input logic [3:0] s1,
                        input logic [31:0] d1,
                        input logic e2, input logic [3:0] s2,
                        input logic [31:0] d2);
      wb_y1_en = e1; wb_y1_sel = s1; wb_y1_data = d1;
      wb_y2_en = e2; wb_y2_sel = s2; wb_y2_data = d2;
      @(posedge clk); #1;
      wb_y1_en = 1'b0;
      wb_y2_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [6];

      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_invalid = 1'b0;
      out_ready  = 1'b1;
      wb_y1_en   = 1'b0; wb_y1_sel = '0; wb_y1_data = '0;
      wb_y2_en   = 1'b0; wb_y2_sel = '0; wb_y2_data = '0;
      drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      idle(2);
      reset_n = 1'b1;

      // Reset state.
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_illegal", 32'(illegal_instr), 0);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_c", op_c, 0);
      chk("rst_fields", {out_alu_op, out_alu_config,
                         out_y1_sel, out_write}, 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;

      // Every register reads zero after reset.
      for (int s = 0; s < 16; s++)
         issue(4'(s), 4'(s), 4'(s), 4'(s), 0, 0, 3'b000,
               0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // Writeback then read; bundle valid one cycle after capture.
      do_wb(1, 3, 32'hDEADBEEF, 0, 0, 0);
      issue(3, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0,
            32'hDEADBEEF, 0, 0, 0);
      chk("valid_after_capture", 32'(out_valid), 1);
      idle(2);

      // Preload reg r with r * 01010101 (reg3 keeps DEADBEEF).
      for (int r = 1; r < 16; r++)
         if (r != 3) begin
            if (r % 2 == 0)
               do_wb(0, 0, 0, 1, 4'(r), 32'h01010101 * r);
            else
               do_wb(1, 4'(r), 32'h01010101 * r, 0, 0, 0);
         end
      do_wb(1, 0, 32'hFFFFFFFF, 0, 0, 0);

      vt[0] = '{1, 2, 4, 15, 0, 32'h0, 3'b000, 32'h01010101,
                32'h02020202, 32'h04040404, 32'h0F0F0F0F};
      vt[1] = '{3, 0, 7, 9, 1, 32'h00001234, 3'b100,
                32'hDEADBEEF, 32'h0, 32'h00001234, 32'h09090909};
      vt[2] = '{0, 0, 0, 0, 0, 32'h0, 3'b010,
                32'h0, 32'h0, 32'h0, 32'h0};
      vt[3] = '{14, 13, 12, 11, 0, 32'h0, 3'b100, 32'h0E0E0E0E,
                32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B};
      vt[4] = '{5, 6, 10, 8, 1, 32'h0000FFFF, 3'b000,
                32'h05050505, 32'h06060606, 32'h0000FFFF,
                32'h08080808};
      vt[5] = '{15, 15, 15, 15, 0, 32'h0, 3'b010, 32'h0F0F0F0F,
                32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
      for (int i = 0; i < 6; i++)
         issue(vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].cc,
               vt[i].k, vt[i].op, 0, 0, 0,
               vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ed);
      idle(2);

      // RAW hazard on reg5, released by a same-cycle writeback.
      issue(0, 0, 0, 0, 0, 0, 3'b000, 5, 0, 2'b01, 0, 0, 0, 0);
      drive(5, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("raw_stall", 32'(in_ready), 0);
         @(posedge clk); #1;
      end
      wb_y1_en = 1'b1; wb_y1_sel = 5; wb_y1_data = 32'h5A5A0005;
      @(negedge clk);
      chk("raw_bypass_ready", 32'(in_ready), 1);
      push(32'h5A5A0005, 0, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wb_y1_en = 1'b0;
      idle(2);

      // Same-register double writeback: Y2 wins.
      do_wb(1, 9, 32'h1, 1, 9, 32'h2);

      // Output stall: bundle held, upstream blocked.
      out_ready = 1'b0;
      issue(9, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h2, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
      in_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_op_a", op_a, 32'h2);
         chk("stall_ready", 32'(in_ready), 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", 32'(in_ready), 1);
      push(32'h01010101, 0, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      idle(2);

      // Invalid instruction: pulse, no capture, no busy bit.
      drive(0, 0, 0, 0, 0, 0, 3'b000, 7, 0, 2'b01);
      in_invalid = 1'b1;
      in_valid   = 1'b1;
      @(negedge clk);
      chk("inv_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_invalid = 1'b0;
      @(negedge clk);
      chk("inv_pulse", 32'(illegal_instr), 1);
      chk("inv_no_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("inv_pulse_end", 32'(illegal_instr), 0);
      @(posedge clk); #1;
      issue(7, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0,
            32'h07070707, 0, 0, 0);
      idle(2);

      // Reset in the middle of a stall.
      out_ready = 1'b0;
      issue(0, 0, 0, 0, 0, 0, 3'b000, 6, 0, 2'b01, 0, 0, 0, 0);
      drive(6, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("pre_rst_stall", 32'(in_ready), 0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      q.delete();
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_busy", 32'(in_ready), 1);
      chk("mid_rst_op_a", op_a, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(3);

      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
